// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//   Bundles the signals between the IR/flag register side and the micro-op
//   sequencer.
//
//   opcode      IR opcode field, valid from T3 onward
//   flag_carry  latched ALU carry flag
//   flag_zero   latched ALU zero flag
//   resume      leaves the HALT state when high
//   ctrl        16-bit datapath control word
//   stage       0-5 = T0-T5, 6 = reset hold, 7 = halt
//   instr_done  high during the final stage of each instruction
//   halted      high while halted
//
//   master: drives opcode/flags/resume and observes the sequencer outputs
//   slave : the sequencer itself
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int OPCODE_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                flag_carry;
  logic                flag_zero;
  logic                resume;
  logic [15:0]         ctrl;
  logic [2:0]          stage;
  logic                instr_done;
  logic                halted;

  modport master (
    output opcode, flag_carry, flag_zero, resume,
    input  ctrl, stage, instr_done, halted
  );

  modport slave (
    input  opcode, flag_carry, flag_zero, resume,
    output ctrl, stage, instr_done, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Micro-op sequencer for the 8-bit SAP-style CPU. Walks the fetch/execute
//   T-states and decodes the IR opcode into a 16-bit datapath control word.
//   Supports early instruction termination, conditional jumps on ALU flags,
//   load-immediate and a HALT state with resume.
//
//   Parameters
//     OPCODE_W   opcode width; only the low 4 bits are decoded, any nonzero
//                upper bit is treated as NOP
//     EARLY_END  1: return to T0 after the last active stage
//                0: always run T0..T5
//
//   Ports
//     clk   system clock, all state updates on its rising edge
//     rst   synchronous active-high reset (one S_RESET hold cycle after it)
//     bus   control_sequencer_if.slave (opcode/flags/resume in,
//           ctrl/stage/instr_done/halted out)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    T0      = 3'd0,
    T1      = 3'd1,
    T2      = 3'd2,
    T3      = 3'd3,
    T4      = 3'd4,
    T5      = 3'd5,
    S_RESET = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  // Control word bit positions; "_N" bits are active-low.
  localparam int FLAGS_LOAD      = 15;
  localparam int PC_INC          = 14;
  localparam int PC_EN           = 13;
  localparam int PC_LOAD         = 12;
  localparam int MAR_ADDR_LOAD_N = 11;
  localparam int MAR_MEM_LOAD_N  = 10;
  localparam int RAM_EN_N        = 9;
  localparam int RAM_LOAD_N      = 8;
  localparam int IR_LOAD_N       = 7;
  localparam int IR_EN_N         = 6;
  localparam int REGA_LOAD_N     = 5;
  localparam int REGA_EN         = 4;
  localparam int ADDER_SUB       = 3;
  localparam int REGB_EN         = 2;
  localparam int REGB_LOAD_N     = 1;
  localparam int OUT_LOAD_N      = 0;

  // Every signal deasserted.
  localparam logic [15:0] IDLE_WORD = 16'h0FE3;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_NOP = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;

  state_t      state;
  state_t      state_next;
  state_t      last_stage;
  logic [15:0] ctrl_w;
  logic        done;
  logic        is_last;
  logic        upper_nz;
  logic [3:0]  op;

  // Opcodes wider than the decoded nibble degrade to NOP when any extra bit
  // is set.
  if (OPCODE_W > 4) begin : g_upper
    assign upper_nz = |bus.opcode[OPCODE_W-1:4];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  assign op = upper_nz ? OP_NOP : bus.opcode[3:0];

  // Last stage that does real work for the current opcode.
  always_comb begin
    case (op)
      OP_ADD, OP_SUB, OP_STA: last_stage = T5;
      OP_LDA:                 last_stage = T4;
      default:                last_stage = T3;
    endcase
  end

  // In full-length mode only T5 ends an instruction; the stages past the
  // last active one simply fall through with the idle word.
  assign is_last = EARLY_END ? (state >= last_stage) : (state == T5);

  // NOTE: reset is synchronous (sampled only at the clock edge) and the state
  // register uses non-blocking assignment so every reader sees the pre-edge
  // value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    ctrl_w     = IDLE_WORD;
    done       = 1'b0;
    state_next = S_RESET;

    case (state)
      S_RESET: state_next = T0;

      S_HALT:  state_next = bus.resume ? T0 : S_HALT;

      T0: begin
        ctrl_w[PC_EN]           = 1'b1;
        ctrl_w[MAR_ADDR_LOAD_N] = 1'b0;
        state_next              = T1;
      end

      T1: begin
        ctrl_w[PC_INC] = 1'b1;
        state_next     = T2;
      end

      T2: begin
        ctrl_w[RAM_EN_N]  = 1'b0;
        ctrl_w[IR_LOAD_N] = 1'b0;
        state_next        = T3;
      end

      T3, T4, T5: begin
        if (state == T3) begin
          // Flags only influence the word here, so JC/JZ look at them in T3.
          case (op)
            OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
              ctrl_w[IR_EN_N]         = 1'b0;
              ctrl_w[MAR_ADDR_LOAD_N] = 1'b0;
            end
            OP_OUT: begin
              ctrl_w[REGA_EN]    = 1'b1;
              ctrl_w[OUT_LOAD_N] = 1'b0;
            end
            OP_JMP: begin
              ctrl_w[IR_EN_N] = 1'b0;
              ctrl_w[PC_LOAD] = 1'b1;
            end
            OP_JC: begin
              if (bus.flag_carry) begin
                ctrl_w[IR_EN_N] = 1'b0;
                ctrl_w[PC_LOAD] = 1'b1;
              end
            end
            OP_JZ: begin
              if (bus.flag_zero) begin
                ctrl_w[IR_EN_N] = 1'b0;
                ctrl_w[PC_LOAD] = 1'b1;
              end
            end
            OP_LDI: begin
              ctrl_w[IR_EN_N]     = 1'b0;
              ctrl_w[REGA_LOAD_N] = 1'b0;
            end
            default: ;
          endcase
        end else if (state == T4) begin
          case (op)
            OP_ADD, OP_SUB: begin
              ctrl_w[RAM_EN_N]    = 1'b0;
              ctrl_w[REGB_LOAD_N] = 1'b0;
            end
            OP_LDA: begin
              ctrl_w[RAM_EN_N]    = 1'b0;
              ctrl_w[REGA_LOAD_N] = 1'b0;
            end
            OP_STA: begin
              ctrl_w[REGA_EN]        = 1'b1;
              ctrl_w[MAR_MEM_LOAD_N] = 1'b0;
            end
            default: ;
          endcase
        end else begin
          case (op)
            OP_ADD, OP_SUB: begin
              ctrl_w[REGB_EN]     = 1'b1;
              ctrl_w[REGA_LOAD_N] = 1'b0;
              ctrl_w[FLAGS_LOAD]  = 1'b1;
              ctrl_w[ADDER_SUB]   = (op == OP_SUB);
            end
            OP_STA: ctrl_w[RAM_LOAD_N] = 1'b0;
            default: ;
          endcase
        end

        // HLT ends at T3 in both modes and parks the sequencer.
        if (state == T3 && op == OP_HLT) begin
          done       = 1'b1;
          state_next = S_HALT;
        end else if (is_last) begin
          done       = 1'b1;
          state_next = T0;
        end else begin
          state_next = state_t'(state + 3'd1);
        end
      end

      default: state_next = S_RESET;
    endcase
  end

  assign bus.ctrl       = ctrl_w;
  assign bus.stage      = state;
  assign bus.instr_done = done;
  assign bus.halted     = (state == S_HALT);

endmodule
